// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-lane arbiter in front of a multi-port fifo.
// Grants up to WRITE requesters per cycle, packs them onto lanes 0..k-1 and sequences flush.
module fifo_wr_arbiter #(
    parameter int DATA  = 32,
    parameter int REQ   = 4,
    parameter int WRITE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [REQ-1:0]        req_v,
    input  logic [REQ*DATA-1:0]   req_d,
    output logic [REQ-1:0]        req_rdy,
    input  logic                  fifo_busy,
    output logic [WRITE-1:0]      fifo_we,
    output logic [WRITE*DATA-1:0] fifo_wd,
    output logic                  fifo_flush
);

    localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
    localparam int GR = (WRITE < REQ) ? WRITE : REQ;

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_next;
    logic [2*REQ-1:0]      v_dbl;
    logic [2*REQ*DATA-1:0] d_dbl;
    logic [REQ-1:0]        rot_v;
    logic [REQ*DATA-1:0]   rot_d;
    logic [REQ-1:0]        rot_gnt;
    logic [2*REQ-1:0]      gnt_dbl;
    logic [WRITE-1:0]      lane_we;
    logic [WRITE*DATA-1:0] lane_d;
    logic                  any_gnt;
    int                    cnt;
    int                    last;

    // Rotate requesters so position 0 is the current round-robin head; the scan is then a
    // plain lowest-first walk and lane k falls out as the k-th hit.
    always_comb begin
        v_dbl   = {req_v, req_v} >> ptr;
        d_dbl   = {req_d, req_d} >> (int'(ptr) * DATA);
        rot_v   = v_dbl[REQ-1:0];
        rot_d   = d_dbl[REQ*DATA-1:0];
        rot_gnt = '0;
        lane_we = '0;
        lane_d  = '0;
        cnt     = 0;
        last    = 0;
        if (!reset && !flush && !fifo_busy) begin
            for (int j = 0; j < REQ; j++) begin
                if (rot_v[j] && (cnt < GR)) begin
                    rot_gnt[j]                 = 1'b1;
                    lane_we[cnt]               = 1'b1;
                    lane_d[cnt*DATA +: DATA]   = rot_d[j*DATA +: DATA];
                    last                       = j;
                    cnt                        = cnt + 1;
                end
            end
        end
        gnt_dbl  = {rot_gnt, rot_gnt} << ptr;
        req_rdy  = gnt_dbl[2*REQ-1:REQ];
        any_gnt  = |rot_gnt;
        ptr_next = PW'((int'(ptr) + last + 1) % REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            fifo_we    <= '0;
            fifo_wd    <= '0;
            fifo_flush <= 1'b0;
        end else if (flush) begin
            ptr        <= '0;
            fifo_we    <= '0;
            fifo_wd    <= '0;
            fifo_flush <= 1'b1;
        end else begin
            fifo_we    <= lane_we;
            fifo_wd    <= lane_d;
            fifo_flush <= 1'b0;
            if (any_gnt) begin
                ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized bench for fifo_wr_arbiter (REQ=4, WRITE=2) against a
// queue-based round-robin reference model.
module tb_fifo_wr_arbiter;

    localparam int DATA  = 32;
    localparam int REQ   = 4;
    localparam int WRITE = 2;

    logic                  clk;
    logic                  reset;
    logic                  flush;
    logic [REQ-1:0]        req_v;
    logic [REQ*DATA-1:0]   req_d;
    logic [REQ-1:0]        req_rdy;
    logic                  fifo_busy;
    logic [WRITE-1:0]      fifo_we;
    logic [WRITE*DATA-1:0] fifo_wd;
    logic                  fifo_flush;

    int total = 0;
    int bad   = 0;

    // Reference state: round-robin head and the beat expected on the fifo ports.
    int                    m_ptr;
    logic [WRITE-1:0]      exp_we;
    logic [WRITE*DATA-1:0] exp_wd;
    logic                  exp_flush;

    fifo_wr_arbiter #(.DATA(DATA), .REQ(REQ), .WRITE(WRITE)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req_v(req_v), .req_d(req_d),
        .req_rdy(req_rdy), .fifo_busy(fifo_busy), .fifo_we(fifo_we), .fifo_wd(fifo_wd),
        .fifo_flush(fifo_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_rdy(input string tag, input logic [REQ-1:0] exp);
        total++;
        assert (req_rdy === exp) else begin
            bad++;
            $error("FAIL %s req_rdy got=%b want=%b", tag, req_rdy, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        total++;
        assert (fifo_we === exp_we) else begin
            bad++;
            $error("FAIL %s fifo_we got=%b want=%b", tag, fifo_we, exp_we);
        end
        total++;
        assert (fifo_wd === exp_wd) else begin
            bad++;
            $error("FAIL %s fifo_wd got=%h want=%h", tag, fifo_wd, exp_wd);
        end
        total++;
        assert (fifo_flush === exp_flush) else begin
            bad++;
            $error("FAIL %s fifo_flush got=%b want=%b", tag, fifo_flush, exp_flush);
        end
    endtask

    // One clock: apply inputs, check grants, advance the model, check the registered beat.
    task automatic cyc(input string tag, input logic r, input logic f, input logic b,
                       input logic [REQ-1:0] v, input logic [REQ*DATA-1:0] d);
        int order[$];
        int limit;
        logic [REQ-1:0] g;
        logic [REQ-1:0] vv;
        vv = v;
        reset = r; flush = f; fifo_busy = b; req_v = v; req_d = d;
        #1;
        g = '0;
        order = {};
        limit = (WRITE < REQ) ? WRITE : REQ;
        if (!r && !f && !b) begin
            for (int j = 0; j < REQ; j++) begin
                if (vv[(m_ptr + j) % REQ] && order.size() < limit)
                    order.push_back((m_ptr + j) % REQ);
            end
        end
        foreach (order[k]) g[order[k]] = 1'b1;
        chk_rdy(tag, g);
        if (r) begin
            exp_we = '0; exp_wd = '0; exp_flush = 1'b0; m_ptr = 0;
        end else if (f) begin
            exp_we = '0; exp_wd = '0; exp_flush = 1'b1; m_ptr = 0;
        end else begin
            exp_flush = 1'b0;
            exp_we = '0;
            exp_wd = '0;
            foreach (order[k]) begin
                exp_we[k] = 1'b1;
                exp_wd[k*DATA +: DATA] = d[order[k]*DATA +: DATA];
            end
            if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % REQ;
        end
        @(posedge clk);
        #1;
        chk_out(tag);
    endtask

    function automatic logic [REQ*DATA-1:0] seq_d(input int base);
        logic [REQ*DATA-1:0] r;
        for (int i = 0; i < REQ; i++) r[i*DATA +: DATA] = DATA'(base + i);
        return r;
    endfunction

    initial begin
        logic [REQ*DATA-1:0] d;
        logic [REQ*DATA-1:0] rd;
        reset = 1'b1; flush = 1'b0; fifo_busy = 1'b0; req_v = '0; req_d = '0;
        m_ptr = 0; exp_we = '0; exp_wd = '0; exp_flush = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with every requester valid
        for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b0, 1'b0, 4'b1111, seq_d(32'h10));

        // Round robin: two cycles cover all four, head returns to 0
        cyc("rr1", 1'b0, 1'b0, 1'b0, 4'b1111, seq_d(32'h10));
        cyc("rr2", 1'b0, 1'b0, 1'b0, 4'b1111, seq_d(32'h10));
        cyc("rr_idle", 1'b0, 1'b0, 1'b0, 4'b0000, seq_d(32'h10));

        // Packing: a lone requester 3 lands on lane 0
        d = '0; d[3*DATA +: DATA] = 32'hdeadbeef;
        cyc("pack", 1'b0, 1'b0, 1'b0, 4'b1000, d);
        cyc("pack_ptr", 1'b0, 1'b0, 1'b0, 4'b1111, seq_d(32'h20));

        // Busy right after a grant: in-flight beat still written, head held
        cyc("busy_pre", 1'b0, 1'b0, 1'b0, 4'b1111, seq_d(32'h30));
        cyc("busy1", 1'b0, 1'b0, 1'b1, 4'b1111, seq_d(32'h40));
        cyc("busy2", 1'b0, 1'b0, 1'b1, 4'b1111, seq_d(32'h40));
        cyc("busy_rel", 1'b0, 1'b0, 1'b0, 4'b1111, seq_d(32'h50));

        // Flush colliding with full request set, after a grant sets a nonzero head
        cyc("fl_pre", 1'b0, 1'b0, 1'b0, 4'b0010, seq_d(32'h60));
        cyc("flush", 1'b0, 1'b1, 1'b0, 4'b1111, seq_d(32'h70));
        cyc("fl_after", 1'b0, 1'b0, 1'b0, 4'b1111, seq_d(32'h80));
        cyc("fl_hold1", 1'b0, 1'b1, 1'b0, 4'b1111, seq_d(32'h80));
        cyc("fl_hold2", 1'b0, 1'b1, 1'b0, 4'b1111, seq_d(32'h80));
        cyc("fl_done", 1'b0, 1'b0, 1'b0, 4'b0000, seq_d(32'h80));

        // Stream from requester 1: words 1..8 in order on lane 0
        for (int w = 1; w <= 8; w++) begin
            d = '0; d[1*DATA +: DATA] = DATA'(w);
            cyc("stream", 1'b0, 1'b0, 1'b0, 4'b0010, d);
        end

        // Reset in the middle of traffic discards the registered beat
        cyc("mid_pre", 1'b0, 1'b0, 1'b0, 4'b1011, seq_d(32'h90));
        cyc("mid_rst", 1'b1, 1'b0, 1'b0, 4'b1111, seq_d(32'ha0));
        cyc("mid_post", 1'b0, 1'b0, 1'b0, 4'b1100, seq_d(32'hb0));

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < REQ; i++) rd[i*DATA +: DATA] = $urandom;
            cyc("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) == 0), 4'($urandom), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
